// File: rtl/cross_bar_dff_router_1xn.sv
// Credit-gated 1-to-N stream router: the header beat's low 16 bits are the packet cost,
// which is charged against the destination channel's credit before the packet is forwarded.
module cross_bar_dff_router_1xn #(
    parameter int MSEL_WIDTH  = 2,
    parameter int CHANNEL_NO  = 2**MSEL_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int CREDIT_INIT = 64
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [MSEL_WIDTH-1:0] s_axis_tdest,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata [CHANNEL_NO],
    output logic [CHANNEL_NO-1:0] m_axis_tvalid,
    output logic [CHANNEL_NO-1:0] m_axis_tlast,
    input  logic [CHANNEL_NO-1:0] m_axis_tready,
    input  logic [CHANNEL_NO-1:0] credit_return_valid,
    input  logic [DATA_WIDTH-1:0] credit_return_count [CHANNEL_NO],
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [MSEL_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] credit     [CHANNEL_NO];
    logic [DATA_WIDTH:0]   credit_sum [CHANNEL_NO];
    logic [DATA_WIDTH-1:0] cost;
    logic                  admit;
    logic                  accept;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high.
    // In IDLE the header is held on the bus (ready low) until its cost fits; it is then
    // accepted as an ordinary beat once the router is ACTIVE.
    assign cost          = DATA_WIDTH'(s_axis_tdata[15:0]);
    assign admit         = (state == IDLE) && s_axis_tvalid && (credit[s_axis_tdest] >= cost);
    assign s_axis_tready = (state == ACTIVE) && (!m_axis_tvalid[sel] || m_axis_tready[sel]);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign dbg_state     = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (admit) next_state = ACTIVE;
            ACTIVE:  if (accept && s_axis_tlast) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= next_state;
            if (state != IDLE && state != ACTIVE) sel <= '0;
            else if (admit) sel <= s_axis_tdest;
        end
    end

    // Deduction and return combine in one cycle; admission guarantees no underflow,
    // so only the upper end needs saturating.
    always_comb begin
        for (int i = 0; i < CHANNEL_NO; i++) begin
            credit_sum[i] = {1'b0, credit[i] - ((admit && s_axis_tdest == MSEL_WIDTH'(i)) ? cost : '0)}
                          + (credit_return_valid[i] ? {1'b0, credit_return_count[i]} : '0);
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < CHANNEL_NO; i++) begin
            if (areset) credit[i] <= DATA_WIDTH'(CREDIT_INIT);
            else if (credit_sum[i][DATA_WIDTH]) credit[i] <= '1;
            else credit[i] <= credit_sum[i][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < CHANNEL_NO; i++) begin
            if (areset) begin
                m_axis_tvalid[i] <= 1'b0;
                m_axis_tlast[i]  <= 1'b0;
                m_axis_tdata[i]  <= '0;
            end else if (accept && sel == MSEL_WIDTH'(i)) begin
                m_axis_tvalid[i] <= 1'b1;
                m_axis_tlast[i]  <= s_axis_tlast;
                m_axis_tdata[i]  <= s_axis_tdata;
            end else if (m_axis_tready[i]) begin
                m_axis_tvalid[i] <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cross_bar_dff_router_1xn.md
CROSS_BAR_DFF_ROUTER_1XN -- requirements
Module: cross_bar_dff_router_1xn

Interface
REQ-001 SHALL have parameter MSEL_WIDTH, default 2, output-select width.
REQ-002 SHALL have parameter CHANNEL_NO, default 2**MSEL_WIDTH, number of output channels.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, stream data width (>= 16).
REQ-004 SHALL have parameter CREDIT_INIT, default 64, per-channel credit loaded at reset.
REQ-005 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port s_axis_tdata  input  DATA_WIDTH  input stream data.
REQ-008 SHALL have port s_axis_tdest  input  MSEL_WIDTH  destination channel, sampled on header beat only.
REQ-009 SHALL have ports s_axis_tvalid input 1, s_axis_tlast input 1, s_axis_tready output 1: input handshake.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH x [CHANNEL_NO]  per-channel output data.
REQ-011 SHALL have ports m_axis_tvalid output, m_axis_tlast output, m_axis_tready input, each 1 x [CHANNEL_NO].
REQ-012 SHALL have port credit_return_valid  input  1 x [CHANNEL_NO]  credit-return strobe per channel.
REQ-013 SHALL have port credit_return_count  input  DATA_WIDTH x [CHANNEL_NO]  credits returned when strobed.

Function
REQ-014 SHALL treat the first beat of each packet as header; s_axis_tdata[15:0] of the header is the packet cost in beats; header is forwarded as a normal beat.
REQ-015 SHALL implement states IDLE and ACTIVE; encoding outside these SHALL return to IDLE with reset values.
REQ-016 IDLE: s_axis_tready=0; when s_axis_tvalid=1 and credit[tdest] >= cost, SHALL latch tdest into sel, subtract cost from credit[sel], enter ACTIVE next cycle.
REQ-017 IDLE with credit[tdest] < cost SHALL stall (no drop, no credit change) until credit suffices.
REQ-018 ACTIVE: each beat SHALL pass through a one-deep output register per channel; s_axis_tready = !m_axis_tvalid[sel] || m_axis_tready[sel].
REQ-019 Accepted input beat SHALL appear on m_axis_*[sel] the following cycle; latency exactly 1 cycle, full throughput 1 beat/cycle.
REQ-020 Output register SHALL hold data/tlast stable while tvalid=1 and tready=0.
REQ-021 On accepted input beat with s_axis_tlast=1 SHALL return to IDLE; the next header is evaluated no earlier than the following cycle.
REQ-022 Non-selected channels SHALL keep m_axis_tvalid=0 once their last registered beat drains.
REQ-023 credit_return_valid[i]=1 SHALL add credit_return_count[i] to credit[i] that cycle, saturating at 2**DATA_WIDTH-1.
REQ-024 Simultaneous return and deduction on the same channel SHALL yield credit - cost + return (saturated) in one cycle.
REQ-025 Cost 0 SHALL always be admitted without credit change.
REQ-026 Beat count is not checked against cost; tlast alone terminates the packet.

Reset
REQ-027 On areset: state=IDLE, sel=0, every credit[i]=CREDIT_INIT, all m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
REQ-028 Reset mid-packet SHALL discard in-flight and remaining beats' state; next post-reset beat is treated as a header.

Verification
REQ-029 Header cost=4, tdest=2, 4 beats, all tready=1 -> beats on channel 2 one cycle later, credit[2] 64->60, back to IDLE after tlast.
REQ-030 credit[1]=3, header cost=5 to channel 1 -> s_axis_tready=0 stall; credit_return 2 on channel 1 -> admitted next cycle, credit[1]=0.
REQ-031 m_axis_tready[0] low 3 cycles mid-packet -> output held stable, s_axis_tready=0 during stall, no beat lost or duplicated.
REQ-032 Credit return of 10 on channel 3 in same cycle as cost-6 admission to channel 3 (credit 64) -> credit[3]=68.
REQ-033 areset asserted on beat 2 of a 5-beat packet -> all outputs invalid next cycle, credits=64, next beat parsed as header.
REQ-034 Back-to-back packets to channels 0,1,0 with cost 0 -> all routed in order, credits unchanged.
